instr_mem_loader: RTL

- Upstream boot stage for Pipeline_CPU. It receives a program as a byte stream, assembles 32-bit instruction words and writes them into the instruction memory.
- Holds the CPU in reset until the whole image is written. It then releases the CPU's reset, so fetch starts from address 0 with a complete image.
- Replaces the bench-side memory preload with a hardware path.

---
 rtl/instr_mem_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream boot loader that fills the Pipeline_CPU
// instruction memory. Optional INSTR_MEM_LOADER_CHECKSUM_EN adds a trailing XOR byte.
module instr_mem_loader #(
    parameter int DEPTH_WORDS = 32,
    parameter int CNT_W       = 16
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        im_we_o,
    output logic [31:0] im_addr_o,
    output logic [31:0] im_wdata_o,
    output logic        cpu_rst_n_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_REL  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       bcnt_q, bcnt_d;
    logic [CNT_W-1:0] word_q, word_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [7:0]       hi_q, hi_d;
    logic [23:0]      shift_q, shift_d;
    logic             we_d;
    logic [31:0]      addr_d, wdata_d;
    logic             cpu_rst_n_d, done_d, err_d;
    logic [15:0]      hdr_n;
    logic             acc;
    state_t           st_last;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    assign hdr_n = {hi_q, byte_i};
    assign acc   = byte_valid_i & byte_ready_o;

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    assign st_last = S_CHK;
    assign byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                          (state_q == S_DATA) || (state_q == S_CHK);
`else
    assign st_last = S_REL;
    assign byte_ready_o = (state_q == S_HDR0) || (state_q == S_HDR1) ||
                          (state_q == S_DATA);
`endif

    // Next-state, word assembly and registered-output next values
    always_comb begin
        state_d     = state_q;
        bcnt_d      = bcnt_q;
        word_d      = word_q;
        n_d         = n_q;
        hi_d        = hi_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = im_addr_o;
        wdata_d     = im_wdata_o;
        cpu_rst_n_d = (state_q == S_DONE);
        done_d      = (state_q == S_DONE);
        err_d       = (state_q == S_ERR);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        unique case (state_q)
            S_HDR0: begin
                if (acc) begin
                    hi_d    = byte_i;
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (acc) begin
                    n_d    = CNT_W'(hdr_n);
                    word_d = '0;
                    bcnt_d = 2'd0;
                    if (hdr_n == 16'd0)
                        state_d = st_last;
                    else if (32'(hdr_n) > 32'(DEPTH_WORDS))
                        state_d = S_ERR;
                    else
                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (acc) begin
                    shift_d = {shift_q[15:0], byte_i};
                    bcnt_d  = bcnt_q + 2'd1;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ byte_i;
`endif
                    if (bcnt_q == 2'd3) begin
                        we_d    = 1'b1;
                        wdata_d = {shift_q, byte_i};
                        addr_d  = 32'(word_q) << 2;
                        word_d  = word_q + CNT_W'(1);
                        if (word_q == n_q - CNT_W'(1))
                            state_d = st_last;
                    end
                end
            end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (acc)
                    state_d = (byte_i == chk_q) ? S_REL : S_ERR;
            end
`endif
            S_REL:   state_d = S_DONE;
            default: state_d = state_q;
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q     <= S_HDR0;
            bcnt_q      <= 2'd0;
            word_q      <= '0;
            n_q         <= '0;
            hi_q        <= 8'd0;
            shift_q     <= 24'd0;
            im_we_o     <= 1'b0;
            im_addr_o   <= 32'd0;
            im_wdata_o  <= 32'd0;
            cpu_rst_n_o <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            chk_q       <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            bcnt_q      <= bcnt_d;
            word_q      <= word_d;
            n_q         <= n_d;
            hi_q        <= hi_d;
            shift_q     <= shift_d;
            im_we_o     <= we_d;
            im_addr_o   <= addr_d;
            im_wdata_o  <= wdata_d;
            cpu_rst_n_o <= cpu_rst_n_d;
            done_o      <= done_d;
            err_o       <= err_d;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
            chk_q       <= chk_d;
`endif
        end
    end

endmodule
